// File: rtl/partitioner_pkg.sv
// Shared definitions for the partitioner: FSM encoding, partition count and
// the layout of the per-partition info word.
package partitioner_pkg;

  localparam int NUM_PART = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_INFO  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int INFO_CNT_LSB = 0;
  localparam int INFO_CNT_W   = 32;
  localparam int INFO_KEY_LSB = 32;
  localparam int INFO_KEY_W   = 2;
  localparam int INFO_W       = INFO_KEY_LSB + INFO_KEY_W;

  function automatic logic [INFO_W-1:0] make_info(input logic [31:0] cnt, input logic [1:0] k);
    logic [INFO_W-1:0] word;
    word = {INFO_W{1'b0}};
    word[INFO_CNT_LSB +: INFO_CNT_W] = cnt;
    word[INFO_KEY_LSB +: INFO_KEY_W] = k;
    return word;
  endfunction

endpackage

// File: rtl/partitioner_if.sv
// Control, input-FIFO and partition-FIFO signals of the partitioner.
// The slave modport is the partitioner's view; master is the environment's.
interface partitioner_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  start;
  logic [31:0]           row_len;
  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;

  logic [DATA_WIDTH-1:0] data_0_din, data_1_din, data_2_din, data_3_din;
  logic                  data_0_wr_en, data_1_wr_en, data_2_wr_en, data_3_wr_en;
  logic                  data_0_full, data_1_full, data_2_full, data_3_full;

  logic [DATA_WIDTH-1:0] info_0_din, info_1_din, info_2_din, info_3_din;
  logic                  info_0_wr_en, info_1_wr_en, info_2_wr_en, info_3_wr_en;
  logic                  info_0_full, info_1_full, info_2_full, info_3_full;

  logic                  paritition_done;
  logic                  busy;

  modport master (
    output start, row_len, in_dout, in_empty,
    output data_0_full, data_1_full, data_2_full, data_3_full,
    output info_0_full, info_1_full, info_2_full, info_3_full,
    input  in_rd_en,
    input  data_0_din, data_1_din, data_2_din, data_3_din,
    input  data_0_wr_en, data_1_wr_en, data_2_wr_en, data_3_wr_en,
    input  info_0_din, info_1_din, info_2_din, info_3_din,
    input  info_0_wr_en, info_1_wr_en, info_2_wr_en, info_3_wr_en,
    input  paritition_done, busy
  );

  modport slave (
    input  start, row_len, in_dout, in_empty,
    input  data_0_full, data_1_full, data_2_full, data_3_full,
    input  info_0_full, info_1_full, info_2_full, info_3_full,
    output in_rd_en,
    output data_0_din, data_1_din, data_2_din, data_3_din,
    output data_0_wr_en, data_1_wr_en, data_2_wr_en, data_3_wr_en,
    output info_0_din, info_1_din, info_2_din, info_3_din,
    output info_0_wr_en, info_1_wr_en, info_2_wr_en, info_3_wr_en,
    output paritition_done, busy
  );
endinterface

// File: rtl/partitioner.sv
// Routes row_len rows from an FWFT input FIFO into four partition FIFOs by a
// 2-bit key, then emits one info word (row count + partition id) per partition.
module partitioner
  import partitioner_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_LSB    = 0
) (
  input  logic          user_clk,
  input  logic          user_rst,
  partitioner_if.slave  bus
);

  logic [1:0]  r_state;
  logic [31:0] r_remaining;
  logic [31:0] r_cnt [NUM_PART];
  logic [1:0]  r_info_idx;
  logic        r_busy;
  logic        r_done;

  logic [1:0]            w_key;
  logic [NUM_PART-1:0]   w_data_full;
  logic [NUM_PART-1:0]   w_info_full;
  logic [NUM_PART-1:0]   w_data_wr_en;
  logic [NUM_PART-1:0]   w_info_wr_en;
  logic                  w_pop;
  logic                  w_info_wr;
  logic [DATA_WIDTH-1:0] w_info_din [NUM_PART];

  assign w_key       = bus.in_dout[KEY_LSB+1:KEY_LSB];
  assign w_data_full = {bus.data_3_full, bus.data_2_full, bus.data_1_full, bus.data_0_full};
  assign w_info_full = {bus.info_3_full, bus.info_2_full, bus.info_1_full, bus.info_0_full};

  // Pop/write decisions; a blocked head row stalls every partition.
  always_comb begin
    w_pop        = 1'b0;
    w_info_wr    = 1'b0;
    w_data_wr_en = {NUM_PART{1'b0}};
    w_info_wr_en = {NUM_PART{1'b0}};
    if (r_state == ST_ROUTE && !bus.in_empty && !w_data_full[w_key] && r_remaining != 32'd0) begin
      w_pop               = 1'b1;
      w_data_wr_en[w_key] = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    if (r_state == ST_INFO && !w_info_full[r_info_idx]) begin
      w_info_wr                = 1'b1;
      w_info_wr_en[r_info_idx] = 1'b1;
    end else begin
      w_info_wr = 1'b0;
    end
    for (int k = 0; k < NUM_PART; k++) begin
      if (w_info_wr_en[k]) begin
        w_info_din[k] = DATA_WIDTH'(make_info(r_cnt[k], k[1:0]));
      end else begin
        w_info_din[k] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  assign bus.in_rd_en     = w_pop;
  assign bus.data_0_wr_en = w_data_wr_en[0];
  assign bus.data_1_wr_en = w_data_wr_en[1];
  assign bus.data_2_wr_en = w_data_wr_en[2];
  assign bus.data_3_wr_en = w_data_wr_en[3];
  assign bus.data_0_din   = w_data_wr_en[0] ? bus.in_dout : {DATA_WIDTH{1'b0}};
  assign bus.data_1_din   = w_data_wr_en[1] ? bus.in_dout : {DATA_WIDTH{1'b0}};
  assign bus.data_2_din   = w_data_wr_en[2] ? bus.in_dout : {DATA_WIDTH{1'b0}};
  assign bus.data_3_din   = w_data_wr_en[3] ? bus.in_dout : {DATA_WIDTH{1'b0}};
  assign bus.info_0_wr_en = w_info_wr_en[0];
  assign bus.info_1_wr_en = w_info_wr_en[1];
  assign bus.info_2_wr_en = w_info_wr_en[2];
  assign bus.info_3_wr_en = w_info_wr_en[3];
  assign bus.info_0_din   = w_info_din[0];
  assign bus.info_1_din   = w_info_din[1];
  assign bus.info_2_din   = w_info_din[2];
  assign bus.info_3_din   = w_info_din[3];
  assign bus.paritition_done = r_done;
  assign bus.busy            = r_busy;

  // Run FSM with remaining-row and per-partition counters.
  always_ff @(posedge user_clk or negedge user_rst) begin
    if (!user_rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= 32'd0;
      r_info_idx  <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k < NUM_PART; k++) begin
        r_cnt[k] <= 32'd0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_remaining <= bus.row_len;
            r_info_idx  <= 2'd0;
            r_busy      <= 1'b1;
            for (int k = 0; k < NUM_PART; k++) begin
              r_cnt[k] <= 32'd0;
            end
            r_state <= (bus.row_len != 32'd0) ? ST_ROUTE : ST_INFO;
          end
        end
        ST_ROUTE: begin
          if (w_pop) begin
            r_remaining  <= r_remaining - 32'd1;
            r_cnt[w_key] <= r_cnt[w_key] + 32'd1;
            if (r_remaining == 32'd1) begin
              r_state <= ST_INFO;
            end
          end
        end
        ST_INFO: begin
          if (w_info_wr) begin
            r_info_idx <= r_info_idx + 2'd1;
            if (r_info_idx == 2'd3) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/partitioner.md
PARTITIONER -- requirements
Module: partitioner

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of every data/info word.
REQ-002 Parameter KEY_LSB, default 0, bit position of the 2-bit partition key in an input row.
REQ-003 Ports, clock and reset first:
- user_clk  in  1  sole clock.
- user_rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse, begin a partition run.
- row_len  in  32  number of rows to route, sampled on start.
- in_dout  in  DATA_WIDTH  input FIFO head (FWFT).
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  input FIFO pop.
- data_k_din  out  DATA_WIDTH  partition k data word, k=0..3.
- data_k_wr_en  out  1  partition k data write.
- data_k_full  in  1  partition k data FIFO full.
- info_k_din  out  DATA_WIDTH  partition k info word.
- info_k_wr_en  out  1  partition k info write.
- info_k_full  in  1  partition k info FIFO full.
- paritition_done  out  1  one-cycle pulse, run complete.
- busy  out  1  high from start acceptance until the done pulse.

Function
REQ-004 States: IDLE, ROUTE, INFO, DONE.
REQ-005 IDLE: on start, latch remaining=row_len, clear cnt_0..3, clear info index; go to ROUTE if row_len!=0, else INFO.
REQ-006 Start while not IDLE is ignored.
REQ-007 key = in_dout[KEY_LSB+1:KEY_LSB]; selected partition = key.
REQ-008 ROUTE pop condition, combinational: ~in_empty && ~data_key_full && remaining!=0.
REQ-009 On pop, same cycle: in_rd_en=1, data_key_wr_en=1, data_key_din=in_dout; other data_*_wr_en=0.
REQ-010 On pop, next edge: remaining decrements, cnt_key increments by 1.
REQ-011 Head row blocked by a full target FIFO stalls routing, no reorder or bypass; other partitions wait.
REQ-012 When remaining reaches 0 (edge of final pop), go to INFO; no pop occurs with remaining==0.
REQ-013 INFO: write partitions 0,1,2,3 in order, one word each.
REQ-014 Info word: [31:0]=cnt_k, [33:32]=k, all other bits 0.
REQ-015 info_k_wr_en asserted, combinational, when info index==k and ~info_k_full; index advances on that edge.
REQ-016 After partition 3 info is written, go to DONE.
REQ-017 DONE: paritition_done=1 for exactly one cycle, busy=0 from the next cycle, return to IDLE.
REQ-018 cnt_k are 32-bit, wrap modulo 2^32; sum of cnt_k equals row_len at DONE.
REQ-019 All write-enables and in_rd_en are 0 outside ROUTE/INFO.

Reset
REQ-020 On user_rst low, asynchronously: state=IDLE, remaining=0, cnt_0..3=0, info index=0, paritition_done=0, busy=0.
REQ-021 Reset mid-run aborts the run; partial FIFO contents are not retracted; no done pulse is generated.
REQ-022 All combinational outputs evaluate to 0 while in reset.

Structure
REQ-023 Shared package holds the state encoding, the info-word field positions and NUM_PART=4.
REQ-024 No sub-module; a single FSM with counters is natural.

Verification
REQ-025 row_len=8, keys 0,1,2,3,0,1,2,3, no backpressure -> 8 pops in 8 consecutive cycles; info counts 2,2,2,2; done pulse 4 cycles after the last pop.
REQ-026 row_len=5, all keys=2, data_2_full high for 3 cycles mid-run -> stall with no pop for those cycles; final info word for partition 2 = 0x2_00000005; others count 0.
REQ-027 row_len=0 -> no pops; four info words with count 0; done pulse.
REQ-028 in_empty toggling every other cycle, row_len=6 -> exactly 6 pops; no pop while empty; in_rd_en never asserted after the 6th pop.
REQ-029 info_1_full high for 10 cycles during INFO -> partition 0 written, then hold; partitions 1..3 written after release, in order.
REQ-030 user_rst asserted after 3 of 8 pops -> outputs cleared immediately; no done pulse; next start with row_len=4 completes with counts summing to 4.
